logic_rs: RTL
=============

# logic_rs

Reservation station for the 32-bit logic functional unit of the Tomasulo core. Accepts issued logic instructions with tagged or ready operands and snoops the common data bus (CDB) for pending operand values. Dispatches operand-complete entries to the logic unit over a valid/ready handshake. Sits between the issue stage and the logic unit's operand inputs.

## Interface
- DEPTH, 4, number of entries (power of two, 2..8)
- TAG_W, 4, producer tag width; tag 0 means "value present"
- DATA_W, 32, operand width
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- ISSUE_VALID  input  1  issue request
- ISSUE_READY  output  1  at least one free entry
- ISSUE_OP  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
- ISSUE_DEST  input  TAG_W  result tag of the instruction
- ISSUE_QJ, ISSUE_QK  input  TAG_W  producer tags of operands A/B (0 = ready)
- ISSUE_VJ, ISSUE_VK  input  DATA_W  operand values, used only when matching Q is 0
- CDB_VALID  input  1  broadcast valid
- CDB_TAG  input  TAG_W  broadcast tag
- CDB_DATA  input  DATA_W  broadcast value
- DISP_VALID  output  1  an entry is dispatchable
- DISP_READY  input  1  logic unit accepts
- DISP_OP  output  2  opcode of dispatched entry
- DISP_A, DISP_B  output  DATA_W  operands
- DISP_DEST  output  TAG_W  result tag
- BUSY_COUNT  output  clog2(DEPTH)+1  occupied entries

## Operation
- Per entry: busy, op, dest, qj, vj, qk, vk.
- Issue: fires when ISSUE_VALID && ISSUE_READY; writes the lowest-index free entry; busy set next edge.
- Issue-time bypass: if CDB_VALID and CDB_TAG equals nonzero ISSUE_QJ (or QK) in the same cycle, store CDB_DATA and q=0.
- Snoop: every busy entry with nonzero qj == CDB_TAG under CDB_VALID loads vj=CDB_DATA, qj=0; same for qk. CDB_TAG 0 is never matched.
- Entry is ready when busy && qj==0 && qk==0.
- Dispatch select: lowest-index ready entry; DISP_* outputs are combinational from registered state. All DISP_* except DISP_VALID are don't-care when DISP_VALID=0, but are driven to 0.
- Dispatch fires on DISP_VALID && DISP_READY; selected entry's busy clears at that edge.
- DISP_VALID must not drop and DISP_* must not change while stalled (DISP_READY=0), unless a lower-index entry becomes ready; a lower-index entry preempts (valid stays 1, payload may change).
- ISSUE_READY = any entry not busy (registered state only); an entry freed by dispatch is reusable the following cycle.
- BUSY_COUNT = number of busy entries; increments/decrements combine when issue and dispatch fire together (net 0).

## Timing
- Reset (async): all busy=0, q fields 0; ISSUE_READY=1, DISP_VALID=0, DISP_* =0, BUSY_COUNT=0. RST mid-operation discards all entries immediately.
- Issue with both operands ready: DISP_VALID at earliest the cycle after the issue edge (1-cycle latency).
- Operand woken by CDB in cycle N: entry eligible for dispatch in cycle N+1.
- Full (BUSY_COUNT=DEPTH): ISSUE_READY=0; ISSUE_VALID ignored.
- Empty: DISP_VALID=0.
- Dispatch of entry i and issue in same cycle: issue takes a different free entry; entry i free next cycle.
- CDB value matching both qj and qk of one entry fills both.

## Test plan
- Reset then issue AND, QJ=QK=0, VJ=0xF0F0F0F0, VK=0xFF00FF00, DISP_READY=1 -> next cycle DISP_VALID=1, DISP_OP=00, A/B as issued, BUSY_COUNT 1 then 0.
- Issue XOR with QJ=3, QK=0; CDB tag 3 data 0x12345678 two cycles later -> DISP_VALID rises the cycle after the broadcast, DISP_A=0x12345678.
- Issue with QJ=5 while CDB broadcasts tag 5 data 0xDEADBEEF same cycle -> entry captured ready, dispatches next cycle with DISP_A=0xDEADBEEF.
- Fill 4 entries with DISP_READY=0 -> ISSUE_READY=0, BUSY_COUNT=4; extra ISSUE_VALID ignored; raise DISP_READY one cycle -> entry 0 leaves, ISSUE_READY=1 the next cycle.
- Entries 1 and 2 ready, DISP_READY=0 for 3 cycles -> DISP_DEST stable at entry 1's tag; then entry 0 wakes via CDB -> selection moves to entry 0.
- Assert RST asynchronously with 3 busy entries -> ISSUE_READY=1, DISP_VALID=0, BUSY_COUNT=0 before the next clock edge.

Source files
------------

// File: rtl/logic_rs_if.sv
// logic_rs_if: issue, CDB snoop and dispatch signals of the logic-unit reservation station.
// Revision 1.0
`default_nettype none

interface logic_rs_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic              issue_ready;
    logic [1:0]        issue_op;
    logic [TAG_W-1:0]  issue_dest;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              disp_valid;
    logic              disp_ready;
    logic [1:0]        disp_op;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic [TAG_W-1:0]  disp_dest;

    logic [CNT_W-1:0]  busy_count;

    modport master (
        output issue_valid, issue_op, issue_dest, issue_qj, issue_qk, issue_vj, issue_vk,
        output cdb_valid, cdb_tag, cdb_data, disp_ready,
        input  issue_ready, disp_valid, disp_op, disp_a, disp_b, disp_dest, busy_count
    );

    modport slave (
        input  issue_valid, issue_op, issue_dest, issue_qj, issue_qk, issue_vj, issue_vk,
        input  cdb_valid, cdb_tag, cdb_data, disp_ready,
        output issue_ready, disp_valid, disp_op, disp_a, disp_b, disp_dest, busy_count
    );
endinterface

`default_nettype wire

// File: rtl/logic_rs.sv
// logic_rs: reservation station for the logic FU; CDB snoop, lowest-index dispatch.
// Revision 1.0
`default_nettype none

module logic_rs #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    logic_rs_if.slave   rs
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [1:0]        op_q   [DEPTH];
    logic [1:0]        op_d   [DEPTH];
    logic [TAG_W-1:0]  dest_q [DEPTH];
    logic [TAG_W-1:0]  dest_d [DEPTH];
    logic [TAG_W-1:0]  qj_q   [DEPTH];
    logic [TAG_W-1:0]  qj_d   [DEPTH];
    logic [TAG_W-1:0]  qk_q   [DEPTH];
    logic [TAG_W-1:0]  qk_d   [DEPTH];
    logic [DATA_W-1:0] vj_q   [DEPTH];
    logic [DATA_W-1:0] vj_d   [DEPTH];
    logic [DATA_W-1:0] vk_q   [DEPTH];
    logic [DATA_W-1:0] vk_d   [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DEPTH-1:0]  ready_vec;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              any_ready;
    logic              any_free;
    logic              issue_fire;
    logic              disp_fire;
    logic              bypass_j;
    logic              bypass_k;

    // Lowest-index ready and free entries; the downward scan lets index 0 win.
    always_comb begin
        ready_vec = '0;
        sel_idx   = '0;
        free_idx  = '0;
        any_ready = 1'b0;
        any_free  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_vec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
            if (ready_vec[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign issue_fire = rs.issue_valid && any_free;
    assign disp_fire  = any_ready && rs.disp_ready;
    assign bypass_j   = rs.cdb_valid && (rs.issue_qj != '0) && (rs.issue_qj == rs.cdb_tag);
    assign bypass_k   = rs.cdb_valid && (rs.issue_qk != '0) && (rs.issue_qk == rs.cdb_tag);

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        dest_d = dest_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        vj_d   = vj_q;
        vk_d   = vk_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && rs.cdb_valid && (qj_q[i] != '0) && (qj_q[i] == rs.cdb_tag)) begin
                qj_d[i] = '0;
                vj_d[i] = rs.cdb_data;
            end
            if (busy_q[i] && rs.cdb_valid && (qk_q[i] != '0) && (qk_q[i] == rs.cdb_tag)) begin
                qk_d[i] = '0;
                vk_d[i] = rs.cdb_data;
            end
        end

        if (disp_fire) begin
            busy_d[sel_idx] = 1'b0;
        end

        // The free slot is never busy, so it cannot collide with snoop or dispatch.
        if (issue_fire) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = rs.issue_op;
            dest_d[free_idx] = rs.issue_dest;
            qj_d[free_idx]   = bypass_j ? '0 : rs.issue_qj;
            vj_d[free_idx]   = bypass_j ? rs.cdb_data : rs.issue_vj;
            qk_d[free_idx]   = bypass_k ? '0 : rs.issue_qk;
            vk_d[free_idx]   = bypass_k ? rs.cdb_data : rs.issue_vk;
        end

        count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            op_q    <= '{default: '0};
            dest_q  <= '{default: '0};
            qj_q    <= '{default: '0};
            qk_q    <= '{default: '0};
            vj_q    <= '{default: '0};
            vk_q    <= '{default: '0};
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            count_q <= count_d;
        end
    end

    assign rs.issue_ready = ~&busy_q;
    assign rs.disp_valid  = any_ready;
    assign rs.disp_op     = any_ready ? op_q[sel_idx]   : '0;
    assign rs.disp_a      = any_ready ? vj_q[sel_idx]   : '0;
    assign rs.disp_b      = any_ready ? vk_q[sel_idx]   : '0;
    assign rs.disp_dest   = any_ready ? dest_q[sel_idx] : '0;
    assign rs.busy_count  = count_q;

endmodule

`default_nettype wire
